// File: rtl/tape_reader_feeder_if.sv
// Level-based frame handshake between the tape reader feeder and the core.
// master drives val/data, slave drives rdy.
interface tape_reader_feeder_if;
    logic       dev_input_val;
    logic [4:0] dev_input_data;
    logic       dev_input_rdy;

    modport master (
        output dev_input_val,
        output dev_input_data,
        input  dev_input_rdy
    );

    modport slave (
        input  dev_input_val,
        input  dev_input_data,
        output dev_input_rdy
    );
endinterface

// File: rtl/tape_reader_feeder.sv
// Tape reader feeder: 5-bit frame FIFO presented to the core by a val/rdy level FSM.
// Define TAPE_READER_GAP_EN to insert GAP_CYCLES idle cycles between delivered frames.
module tape_reader_feeder #(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 100
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     wr_en,
    input  logic [4:0]               wr_data,
    input  logic                     flush,
    tape_reader_feeder_if.master     dev,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    if (DEPTH < 4 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two in 4..256");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 65535) begin : g_bad_gap
        $error("GAP_CYCLES must be in 1..65535");
    end

`ifdef TAPE_READER_GAP_EN
    typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;
    logic [15:0] gap_cnt, gap_nx;
`else
    typedef enum logic {IDLE, PRESENT} state_t;
`endif

    state_t        state, state_nx;
    logic [4:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr_acc, pop, launch;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign wr_acc = wr_en & ~flush & ~full;
    assign pop    = (state == PRESENT) & ~dev.dev_input_rdy & ~flush;
    assign launch = ~empty & dev.dev_input_rdy;

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, pop};
            // A write into a full FIFO is lost even if a pop frees a slot this cycle.
            if (wr_en && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
`ifdef TAPE_READER_GAP_EN
            gap_cnt <= '0;
`endif
        end else begin
            state   <= state_nx;
`ifdef TAPE_READER_GAP_EN
            gap_cnt <= gap_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
`ifdef TAPE_READER_GAP_EN
        gap_nx   = gap_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (launch) state_nx = PRESENT;
            end
            PRESENT: begin
                if (!dev.dev_input_rdy) begin
`ifdef TAPE_READER_GAP_EN
                    state_nx = GAP;
                    gap_nx   = 16'(GAP_CYCLES - 1);
`else
                    state_nx = IDLE;
`endif
                end
            end
`ifdef TAPE_READER_GAP_EN
            // Last gap cycle doubles as the idle sample so spacing is exactly GAP_CYCLES.
            GAP: begin
                if (gap_cnt == '0) state_nx = launch ? PRESENT : IDLE;
                else gap_nx = gap_cnt - 16'd1;
            end
`endif
            default: state_nx = IDLE;
        endcase
        if (flush) begin
            state_nx = IDLE;
`ifdef TAPE_READER_GAP_EN
            gap_nx   = '0;
`endif
        end
    end

    always_comb begin
        dev.dev_input_val  = 1'b0;
        dev.dev_input_data = '0;
        if (state == PRESENT) begin
            dev.dev_input_val  = 1'b1;
            dev.dev_input_data = mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_tape_reader_feeder.sv
// Randomised scoreboard bench for tape_reader_feeder against a queue-based model.
// Frames expected at the consumer are queued by the model and checked by a monitor.
module tb_tape_reader_feeder;

    localparam int DEPTH = 16;
    localparam int GAP_CYCLES = 3;
`ifdef TAPE_READER_GAP_EN
    localparam int GAP_EN = 1;
`else
    localparam int GAP_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       wr_en = 1'b0;
    logic [4:0] wr_data = '0;
    logic       flush = 1'b0;
    logic       full, empty, overflow;
    logic [4:0] count;

    tape_reader_feeder_if dev_if ();

    tape_reader_feeder #(.DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_data(wr_data),
        .flush(flush), .dev(dev_if.master), .full(full), .empty(empty),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int shown = 0;

    // Model: a queue of frames, whether the head is on offer, remaining gap.
    int q[$];
    int exp_q[$];
    bit m_pres;
    int m_gap;
    bit m_ovf;
    bit s_val;

    function automatic void chk(string n, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (shown < 60) begin
                shown++;
                $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
            end
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        exp_q.delete();
        m_pres = 0;
        m_gap = 0;
        m_ovf = 0;
    endfunction

    function automatic void start_frame();
        m_pres = 1;
        exp_q.push_back(q[0]);
    endfunction

    function automatic void model_edge();
        int sz;
        bit go;
        if (!resetn) begin
            model_reset();
            return;
        end
        if (flush) begin
            q.delete();
            m_pres = 0;
            m_gap = 0;
            m_ovf = 0;
            return;
        end
        sz = q.size();
        go = (sz > 0) && dev_if.dev_input_rdy;
        if (m_pres) begin
            if (!dev_if.dev_input_rdy) begin
                void'(q.pop_front());
                m_pres = 0;
                m_gap = GAP_EN ? GAP_CYCLES : 0;
            end
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0 && go) start_frame();
        end else if (go) begin
            start_frame();
        end
        if (wr_en) begin
            if (sz == DEPTH) m_ovf = 1;
            else q.push_back(int'(wr_data));
        end
    endfunction

    function automatic void check_all();
        chk("val", int'(dev_if.dev_input_val), int'(m_pres));
        chk("data", int'(dev_if.dev_input_data), m_pres ? q[0] : 0);
        chk("count", int'(count), q.size());
        chk("full", int'(full), int'(q.size() == DEPTH));
        chk("empty", int'(empty), int'(q.size() == 0));
        chk("overflow", int'(overflow), int'(m_ovf));
    endfunction

    task automatic step(input bit we, input int wd, input bit fl, input bit r,
                        input bit auto_r);
        @(negedge clk);
        check_all();
        s_val = dev_if.dev_input_val;
        wr_en = we;
        wr_data = 5'(wd);
        flush = fl;
        dev_if.dev_input_rdy = auto_r ? ~dev_if.dev_input_val : r;
        @(posedge clk);
        model_edge();
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && (q.size() > 0 || m_pres || m_gap > 0); i++)
            step(0, 0, 0, 0, 1);
    endtask

    task automatic wait_val();
        s_val = 0;
        for (int i = 0; i < 20 && !s_val; i++) step(0, 0, 0, 1, 0);
        chk("reach_present", int'(s_val), 1);
    endtask

    // Scoreboard monitor: each new presentation must carry the next expected frame.
    initial begin : monitor
        bit pv;
        int e;
        pv = 0;
        forever begin
            @(negedge clk);
            if (dev_if.dev_input_val && !pv) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", int'(dev_if.dev_input_data), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame", int'(dev_if.dev_input_data), e);
                end
            end
            pv = dev_if.dev_input_val;
        end
    end

    initial begin : stim
        int zeros, seen, gap_len;
        dev_if.dev_input_rdy = 1'b0;
        model_reset();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        #1 resetn = 1'b1;

        // Single frame latency and release.
        step(1, 5'h1F, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Overfill by one, then drain in order.
        for (int i = 0; i <= 16; i++) step(1, i, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        drain();

        // Pop and write in the same cycle on a full FIFO.
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < DEPTH; i++) step(1, 20 + i, 0, 0, 0);
        wait_val();
        step(1, 5'h07, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        drain();

        // Spacing between two back-to-back frames.
        step(0, 0, 1, 0, 0);
        step(1, 5'h03, 0, 0, 0);
        step(1, 5'h04, 0, 0, 0);
        zeros = 0;
        seen = 0;
        gap_len = -1;
        for (int i = 0; i < 40 && gap_len < 0; i++) begin
            step(0, 0, 0, 0, 1);
            if (s_val && seen == 0) seen = 1;
            else if (!s_val && seen == 1) zeros++;
            else if (s_val && seen == 1) gap_len = zeros;
        end
        chk("gap_len", gap_len, GAP_EN ? GAP_CYCLES : 1);
        drain();

        // Flush while presenting.
        for (int i = 0; i < 4; i++) step(1, 8 + i, 0, 0, 0);
        wait_val();
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 5'h0A, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
        drain();

        // Asynchronous reset while presenting.
        step(1, 5'h15, 0, 0, 0);
        step(1, 5'h16, 0, 0, 0);
        wait_val();
        #2 resetn = 1'b0;
        #1;
        chk("rst_val", int'(dev_if.dev_input_val), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        model_reset();
        step(0, 0, 0, 1, 0);
        #1 resetn = 1'b1;
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);
        step(1, 5'h11, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);
        drain();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 55), int'($urandom_range(0, 31)),
                 ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 60), 0);
        end
        drain();
        step(0, 0, 0, 0, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tape_reader_feeder.md
TAPE_READER_FEEDER -- requirements
Module: tape_reader_feeder

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in 5-bit frames; power of two, 4..256.
REQ-002 Parameter GAP_CYCLES, default 100, idle clk cycles between delivered frames (used only with the gap feature); range 1..65535.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  write-strobe, one frame per cycle.
REQ-006 wr_data  input  5  frame to enqueue.
REQ-007 flush  input  1  synchronous FIFO clear and handshake abort.
REQ-008 dev_input_rdy  input  1  core ready level, from soc_top.
REQ-009 dev_input_val  output  1  frame-valid level, to soc_top.
REQ-010 dev_input_data  output  5  frame level, to soc_top.
REQ-011 full, empty  output  1 each  FIFO status.
REQ-012 count  output  clog2(DEPTH)+1  frames currently queued.
REQ-013 overflow  output  1  sticky: a write was dropped.

Function
REQ-014 The FIFO SHALL be circular, pointers wrapping modulo DEPTH; a write SHALL be accepted only when wr_en=1, flush=0 and full=0 in that cycle.
REQ-015 A write with full=1 SHALL be dropped and set overflow, even if a pop occurs in the same cycle.
REQ-016 Simultaneous accepted write and pop SHALL leave count unchanged.
REQ-017 The handshake FSM SHALL have states IDLE, PRESENT, GAP.
REQ-018 IDLE -> PRESENT when empty=0 and dev_input_rdy=1; next cycle dev_input_val=1 and dev_input_data=FIFO head.
REQ-019 In PRESENT, dev_input_val and dev_input_data SHALL stay stable until dev_input_rdy is sampled 0.
REQ-020 On sampling dev_input_rdy=0 in PRESENT, the head SHALL be popped and dev_input_val SHALL be 0 from the next cycle, going to GAP (feature on) or IDLE (feature off).
REQ-021 GAP SHALL last exactly GAP_CYCLES cycles with dev_input_val=0, then return to IDLE.
REQ-022 Latency: frame enqueued into an empty FIFO with rdy=1 in IDLE SHALL reach dev_input_val=1 two cycles after the wr_en cycle.
REQ-023 dev_input_data SHALL read 0 whenever dev_input_val=0.
REQ-024 flush SHALL, next cycle, set count=0, empty=1, dev_input_val=0, state IDLE, and clear overflow; a frame being presented SHALL be discarded; wr_en in the flush cycle SHALL be ignored.
REQ-025 A dev_input_rdy fall in IDLE or GAP SHALL have no effect.

Reset
REQ-026 resetn=0 SHALL immediately force: state IDLE, pointers 0, count=0, empty=1, full=0, overflow=0, dev_input_val=0, dev_input_data=0, gap counter 0.
REQ-027 Reset mid-PRESENT SHALL discard all queued frames; FIFO storage contents need no reset.

Configuration
REQ-028 Macro TAPE_READER_GAP_EN: defined -> GAP state and a 16-bit gap counter SHALL exist per REQ-021.
REQ-029 Undefined -> no GAP state or counter; PRESENT returns straight to IDLE, allowing back-to-back frames; GAP_CYCLES ignored.

Verification
REQ-030 Reset, write 5'h1F, rdy=1 -> val=1, data=5'h1F two cycles after write; drop rdy -> val=0 next cycle, count=0, empty=1.
REQ-031 DEPTH=16: write 17 frames 0..16 with rdy=0 -> count=16, full=1, overflow=1; then drain via handshake -> frames 0..15 in order, frame 16 never appears.
REQ-032 Gap on, GAP_CYCLES=3, two frames queued, rdy toggled promptly -> exactly 3 val=0 cycles between frames; gap off -> 1 val=0 cycle.
REQ-033 Full FIFO, pop and write same cycle -> write dropped, overflow=1, count=15.
REQ-034 flush during PRESENT with 4 frames queued -> next cycle val=0, count=0, overflow=0; later write 5'h0A delivered normally.
REQ-035 resetn low mid-PRESENT -> val=0 asynchronously, count=0; no frame delivered after release until a new write.
